l0_stagger_buf: RTL

L0_STAGGER_BUF -- requirements
Module: l0_stagger_buf

---
 rtl/l0_pkg.sv | 13 +
 rtl/l0_stagger_buf_if.sv | 30 +++
 rtl/l0_row_fifo.sv | 44 ++++
 rtl/l0_stagger_buf.sv | 91 +++++++++
 4 files changed

// File: rtl/l0_pkg.sv
// Shared defaults and read-mode encodings for the L0 stagger buffer.
package l0_pkg;

  localparam int unsigned L0_ROW   = 8;
  localparam int unsigned L0_BW    = 4;
  localparam int unsigned L0_DEPTH = 64;

  typedef enum logic {
    L0_MODE_BCAST   = 1'b0,
    L0_MODE_STAGGER = 1'b1
  } l0_mode_e;

endpackage

// File: rtl/l0_stagger_buf_if.sv
// Write/read bus of the L0 stagger buffer; master drives requests, slave returns data and flags.
interface l0_stagger_buf_if
  import l0_pkg::*;
#(
  parameter int unsigned ROW = L0_ROW,
  parameter int unsigned BW  = L0_BW
) ();

  logic              wr;
  logic              rd;
  logic              mode;
  logic [ROW*BW-1:0] in;
  logic [ROW*BW-1:0] out;
  logic [ROW-1:0]    o_valid;
  logic              o_full;
  logic              o_ready;
  logic              o_ovf;
  logic              o_udf;

  modport master (
    output wr, rd, mode, in,
    input  out, o_valid, o_full, o_ready, o_ovf, o_udf
  );

  modport slave (
    input  wr, rd, mode, in,
    output out, o_valid, o_full, o_ready, o_ovf, o_udf
  );

endinterface

// File: rtl/l0_row_fifo.sv
// Single-row FIFO with wrap-bit pointers; head is presented combinationally on rdata.
module l0_row_fifo #(
  parameter int unsigned BW    = 4,
  parameter int unsigned DEPTH = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [BW-1:0] wdata,
  output logic [BW-1:0] rdata,
  output logic          empty,
  output logic          full
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [BW-1:0] mem_q [DEPTH];
  logic [AW:0]   wptr_q;
  logic [AW:0]   rptr_q;
  logic          do_push;
  logic          do_pop;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/l0_stagger_buf.sv
// ROW parallel row FIFOs written together, read in broadcast or (with L0_STAGGER_BUF_STAGGER_EN)
// staggered order via a registered pop-enable vector.
module l0_stagger_buf
  import l0_pkg::*;
#(
  parameter int unsigned ROW   = L0_ROW,
  parameter int unsigned BW    = L0_BW,
  parameter int unsigned DEPTH = L0_DEPTH
) (
  input logic              clk,
  input logic              reset,
  l0_stagger_buf_if.slave  bus
);

  logic [ROW-1:0]    rd_en_q;
  logic [ROW-1:0]    rd_en_d;
  logic [ROW-1:0]    empty;
  logic [ROW-1:0]    full;
  logic [ROW-1:0]    pop;
  logic [ROW-1:0]    valid_q;
  logic [ROW*BW-1:0] head;
  logic [ROW*BW-1:0] out_q;
  logic              full_any;
  logic              push;
  logic              ovf_q;
  logic              udf_q;

  assign full_any = |full;
  assign push     = bus.wr & ~full_any;
  assign pop      = rd_en_q & ~empty;

`ifdef L0_STAGGER_BUF_STAGGER_EN
  l0_mode_e mode_q;
  l0_mode_e mode_eff;

  // A mode change only lands once every in-flight pop has drained.
  assign mode_eff = (rd_en_q == '0) ? l0_mode_e'(bus.mode) : mode_q;
  assign rd_en_d  = (mode_eff == L0_MODE_STAGGER) ? {rd_en_q[ROW-2:0], bus.rd} : {ROW{bus.rd}};

  always_ff @(posedge clk) begin
    if (!reset) mode_q <= L0_MODE_BCAST;
    else        mode_q <= mode_eff;
  end
`else
  logic unused_mode;
  assign unused_mode = bus.mode;
  assign rd_en_d     = {ROW{bus.rd}};
`endif

  for (genvar i = 0; i < ROW; i++) begin : g_row
    l0_row_fifo #(
      .BW    (BW),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop[i]),
      .wdata (bus.in[BW*i +: BW]),
      .rdata (head[BW*i +: BW]),
      .empty (empty[i]),
      .full  (full[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_en_q <= '0;
      out_q   <= '0;
      valid_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      rd_en_q <= rd_en_d;
      valid_q <= pop;
      for (int i = 0; i < ROW; i++) begin
        if (pop[i]) out_q[BW*i +: BW] <= head[BW*i +: BW];
      end
      if (bus.wr && full_any)     ovf_q <= 1'b1;
      if ((rd_en_q & empty) != '0) udf_q <= 1'b1;
    end
  end

  assign bus.out     = out_q;
  assign bus.o_valid = valid_q;
  assign bus.o_full  = full_any;
  assign bus.o_ready = ~|empty;
  assign bus.o_ovf   = ovf_q;
  assign bus.o_udf   = udf_q;

endmodule
